// File: rtl/me_pixel_mem_server.sv
// Memory-side responder for the motion estimator: loads a 16x16 reference block
// and a 32x32 search window from a byte stream, then serves registered reads.
// Ports: clock/reset (async, active-high); pix_valid/pix_ready/pix_data/pix_last
// load stream; frame_ready/frame_err status; start/completed run handshake;
// AddressR/AddressS1/AddressS2 read addresses; R/S1/S2 read data (1-cycle latency).
// Option: define ME_FRAME_CKSUM_EN to add the cksum[15:0] stream checksum port.

module me_pixel_mem_server #(
  parameter int DATA_W  = 8,
  parameter int R_DEPTH = 256,
  parameter int S_DEPTH = 1024,
  parameter int RA_W    = 8,
  parameter int SA_W    = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_last,
  output logic              frame_ready,
  output logic              frame_err,
  input  logic              start,
  input  logic              completed,
  input  logic [RA_W-1:0]   AddressR,
  input  logic [SA_W-1:0]   AddressS1,
  input  logic [SA_W-1:0]   AddressS2,
  output logic [DATA_W-1:0] R,
  output logic [DATA_W-1:0] S1,
`ifdef ME_FRAME_CKSUM_EN
  output logic [DATA_W-1:0] S2,
  output logic [15:0]       cksum
`else
  output logic [DATA_W-1:0] S2
`endif
);

  typedef enum logic [2:0] {
    LOAD_R,
    LOAD_S,
    READY,
    SERVE,
    DRAIN
  } state_t;

  localparam logic [SA_W-1:0] RLAST = SA_W'(R_DEPTH - 1);
  localparam logic [SA_W-1:0] SLAST = SA_W'(S_DEPTH - 1);

  state_t state, nstate;
  logic [SA_W-1:0] wcnt, wnext;
  logic acc, final_b, err_set, clr;

  logic [DATA_W-1:0] rmem [R_DEPTH];
  logic [DATA_W-1:0] smem [S_DEPTH];

  assign acc     = pix_valid && pix_ready;
  assign final_b = (state == LOAD_S) && (wcnt == SLAST);
  // A misplaced or missing pix_last is flagged but never stalls the load.
  assign err_set = acc && (pix_last != final_b);
  assign clr     = (state == DRAIN) && (nstate == LOAD_R);

  always_comb begin
    nstate = state;
    wnext  = wcnt;
    unique case (state)
      LOAD_R: begin
        if (acc) begin
          if (wcnt == RLAST) begin
            wnext  = '0;
            nstate = LOAD_S;
          end else begin
            wnext = wcnt + 1'b1;
          end
        end
      end
      LOAD_S: begin
        if (acc) begin
          if (wcnt == SLAST) begin
            wnext  = '0;
            nstate = READY;
          end else begin
            wnext = wcnt + 1'b1;
          end
        end
      end
      READY: begin
        if (start) nstate = SERVE;
      end
      SERVE: begin
        if (completed || !start) nstate = DRAIN;
      end
      DRAIN: begin
        if (!start) nstate = LOAD_R;
      end
      default: nstate = LOAD_R;
    endcase
  end

  // Status flags are registered from the next state so they change
  // on the same edge as the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= LOAD_R;
      wcnt        <= '0;
      pix_ready   <= 1'b0;
      frame_ready <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= nstate;
      wcnt        <= wnext;
      pix_ready   <= (nstate == LOAD_R) || (nstate == LOAD_S);
      frame_ready <= (nstate == READY) || (nstate == SERVE);
      if (clr)
        frame_err <= 1'b0;
      else if (err_set)
        frame_err <= 1'b1;
    end
  end

  // Memory arrays carry no reset; partial data survives a reset.
  always_ff @(posedge clock) begin
    if (acc && state == LOAD_R)
      rmem[wcnt[RA_W-1:0]] <= pix_data;
    if (acc && state == LOAD_S)
      smem[wcnt] <= pix_data;
  end

  // Reads run in every state; same-cycle write returns old data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      R  <= '0;
      S1 <= '0;
      S2 <= '0;
    end else begin
      R  <= rmem[AddressR];
      S1 <= smem[AddressS1];
      S2 <= smem[AddressS2];
    end
  end

`ifdef ME_FRAME_CKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cksum <= '0;
    else if (clr)
      cksum <= '0;
    else if (acc)
      cksum <= cksum + 16'(pix_data);
  end
`endif

endmodule

// File: tb/tb_me_pixel_mem_server.sv
// Scoreboard bench for me_pixel_mem_server: loads frames, checks status flags,
// pix_last errors, reset mid-load and read data against a memory model.

module tb_me_pixel_mem_server;

  logic       clock = 1'b0;
  logic       reset;
  logic       pix_valid, pix_ready, pix_last;
  logic [7:0] pix_data;
  logic       frame_ready, frame_err;
  logic       start, completed;
  logic [7:0] AddressR;
  logic [9:0] AddressS1, AddressS2;
  logic [7:0] R, S1, S2;
  logic [15:0] cksum;

  always #5 clock = ~clock;

  me_pixel_mem_server dut (
    .clock(clock),
    .reset(reset),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data(pix_data),
    .pix_last(pix_last),
    .frame_ready(frame_ready),
    .frame_err(frame_err),
    .start(start),
    .completed(completed),
    .AddressR(AddressR),
    .AddressS1(AddressS1),
    .AddressS2(AddressS2),
    .R(R),
    .S1(S1),
`ifdef ME_FRAME_CKSUM_EN
    .cksum(cksum),
`endif
    .S2(S2)
  );

  typedef struct {
    logic [7:0] r, s1, s2;
    bit vr, vs1, vs2;
  } exp_t;

  exp_t q[$];
  logic [7:0] rm [256];
  logic [7:0] sm [1024];
  bit rv [256];
  bit sv [1024];
  logic [15:0] sum;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pb(input int mode, input int k);
    int j;
    j = k - 256;
    if (mode == 2) return 8'hFF;
    if (k < 256) return (mode == 0) ? 8'(k) : 8'(k * 3 + 1);
    return (mode == 0) ? 8'(j * 7) : 8'(j * 5 + 9);
  endfunction

  // push expectation for current addresses, clock once, pop and compare
  task automatic cyc();
    exp_t e;
    e.r   = rm[AddressR];
    e.vr  = rv[AddressR];
    e.s1  = sm[AddressS1];
    e.vs1 = sv[AddressS1];
    e.s2  = sm[AddressS2];
    e.vs2 = sv[AddressS2];
    q.push_back(e);
    @(posedge clock);
    #1;
    e = q.pop_front();
    if (e.vr)  chk("R", R, e.r);
    if (e.vs1) chk("S1", S1, e.s1);
    if (e.vs2) chk("S2", S2, e.s2);
  endtask

  task automatic rnd_addr();
    AddressR  = 8'($urandom);
    AddressS1 = 10'($urandom);
    AddressS2 = ($urandom_range(0, 3) == 0) ? AddressS1 : 10'($urandom);
  endtask

  task automatic load(input int mode, input int lp1, input int lp2,
                      input int stop_at);
    bit rdy;
    sum = '0;
    for (int k = 0; k < 1280; k++) begin
      if (k == stop_at) begin
        pix_valid = 1'b0;
        return;
      end
      pix_data  = pb(mode, k);
      pix_last  = (k == lp1) || (k == lp2);
      pix_valid = 1'b1;
      rnd_addr();
      if (k < 256) AddressR = 8'(k);
      else AddressS1 = 10'(k - 256);
      if (k == 1279) chk("fr_pre", frame_ready, 1'b0);
      rdy = 1'b0;
      for (int n = 0; n < 50 && !rdy; n++) begin
        rdy = pix_ready;
        cyc();
      end
      chk("acc_to", rdy, 1'b1);
      if (!rdy) return;
      if (k < 256) begin
        rm[k] = pix_data;
        rv[k] = 1'b1;
      end else begin
        sm[k-256] = pix_data;
        sv[k-256] = 1'b1;
      end
      sum = sum + 16'(pix_data);
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    chk("fr_post", frame_ready, 1'b1);
    chk("rdy_off", pix_ready, 1'b0);
`ifdef ME_FRAME_CKSUM_EN
    chk("cksum", cksum, sum);
`endif
  endtask

  initial begin
    reset = 1'b1;
    pix_valid = 1'b0;
    pix_last = 1'b0;
    pix_data = '0;
    start = 1'b0;
    completed = 1'b0;
    AddressR = '0;
    AddressS1 = '0;
    AddressS2 = '0;
    for (int i = 0; i < 256; i++) rv[i] = 1'b0;
    for (int i = 0; i < 1024; i++) sv[i] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_prdy", pix_ready, 1'b0);
    chk("rst_fr", frame_ready, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_R", R, 8'h00);
    chk("rst_S1", S1, 8'h00);
    chk("rst_S2", S2, 8'h00);
    reset = 1'b0;

    // frame 1: clean load
    load(0, 1279, -1, -1);
    chk("err1", frame_err, 1'b0);
    AddressR = 8'd5;
    AddressS1 = 10'd3;
    AddressS2 = 10'd3;
    cyc();
    chk("R5", R, 8'h05);
    chk("S1_3", S1, 8'h15);
    chk("S2_3", S2, 8'h15);

    start = 1'b1;
    cyc();
    chk("fr_serve", frame_ready, 1'b1);
    for (int i = 0; i < 4112; i++) begin
      rnd_addr();
      cyc();
    end
    completed = 1'b1;
    cyc();
    completed = 1'b0;
    chk("fr_drain", frame_ready, 1'b0);
    chk("prdy_drain", pix_ready, 1'b0);
    cyc();
    chk("prdy_hold", pix_ready, 1'b0);
    start = 1'b0;
    cyc();
    chk("prdy_back", pix_ready, 1'b1);

    // frame 2: stray pix_last on R byte 100
    load(1, 100, 1279, -1);
    chk("err2", frame_err, 1'b1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("err2_drain", frame_err, 1'b1);
    chk("fr2_drain", frame_ready, 1'b0);
    cyc();
    chk("err2_clr", frame_err, 1'b0);
    chk("prdy2", pix_ready, 1'b1);

    // start/completed ignored in LOAD_R
    start = 1'b1;
    completed = 1'b1;
    repeat (3) cyc();
    chk("ign_prdy", pix_ready, 1'b1);
    chk("ign_fr", frame_ready, 1'b0);
    start = 1'b0;
    completed = 1'b0;

    // frame 3: partial load, reset at S byte 500
    load(1, -1, -1, 256 + 500);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_R", R, 8'h00);
    chk("mid_S1", S1, 8'h00);
    chk("mid_S2", S2, 8'h00);
    chk("mid_fr", frame_ready, 1'b0);
    chk("mid_prdy", pix_ready, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc();
    chk("mid_prdy2", pix_ready, 1'b1);
    chk("mid_fr2", frame_ready, 1'b0);

    // frame 4: all 8'hFF, pix_last missing on final byte
    load(2, -1, -1, -1);
    chk("err4", frame_err, 1'b1);
`ifdef ME_FRAME_CKSUM_EN
    chk("cksum_ff", cksum, 16'hFB00);
`endif
    for (int i = 0; i < 16; i++) begin
      rnd_addr();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
